// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single main-memory port between the instruction-side requester
// (fetch / I-cache fill) and the data-side requester (memory stage / D-cache).
// One access is in flight at a time. The grant is held until memory reports
// completion, or until the timeout expires.
//
// Arbitration: the data side wins a tie because it belongs to the older
// instruction. A streak counter limits how many consecutive D grants can be
// made while I is waiting. Once the limit is reached, I is forced through.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   i_req / i_addr      instruction read request (level) and address
//   i_done / i_rdata    one-cycle completion strobe, registered read data
//   d_req / d_wr        data request (level), 1 = write
//   d_addr / d_wdata    data address and write data
//   d_done / d_rdata    one-cycle completion strobe, registered read data
//   mem_req             one-cycle request pulse to memory
//   mem_wr              write enable, qualified by mem_req
//   mem_addr/mem_wdata  latched for the whole access
//   mem_rdata/mem_done  memory read data and completion strobe
//   err                 sticky timeout flag, cleared only by reset
//   dbgState            current FSM state (IDLE=0, IBUSY=1, DBUSY=2, DONE=3)
//
// Handshake: a requester raises *_req together with its address/data and
// keeps it high until it sees its *_done strobe. In the DONE cycle requests
// are ignored, so the requester may drop or change its request for the
// following cycle. The memory sees exactly one mem_req pulse per access and
// answers with one mem_done strobe, which may coincide with mem_req.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              err,
    output logic [1:0]        dbgState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        DONE  = 2'd3
    } stateT;

    // The streak counter must be able to hold STARVE_LIMIT itself, because it
    // saturates there.
    localparam int STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);

    stateT                state;
    stateT                nextState;
    logic [STREAK_W-1:0]  streak;
    logic [TMO_W-1:0]     tmoCnt;

    // Decoded control, produced by the next-state logic.
    logic                 grantI;
    logic                 grantD;
    logic                 busyDone;
    logic                 timeoutHit;
    logic                 busy;

    assign busy     = (state == IBUSY) || (state == DBUSY);
    assign dbgState = state;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and grant decode
    // -------------------------------------------------------------------------
    always_comb begin
        nextState  = state;
        grantI     = 1'b0;
        grantD     = 1'b0;
        busyDone   = 1'b0;
        timeoutHit = 1'b0;

        case (state)
            IDLE: begin
                // D wins a tie unless I has already waited through
                // STARVE_LIMIT consecutive D grants.
                if (d_req && (!i_req || (streak < STREAK_MAX))) begin
                    grantD    = 1'b1;
                    nextState = DBUSY;
                end else if (i_req) begin
                    grantI    = 1'b1;
                    nextState = IBUSY;
                end
            end

            IBUSY, DBUSY: begin
                // A completion in the last allowed cycle still counts as a
                // success; the timeout fires only without mem_done.
                if (mem_done) begin
                    busyDone  = 1'b1;
                    nextState = DONE;
                end else if (tmoCnt == TMO_LAST) begin
                    timeoutHit = 1'b1;
                    nextState  = IDLE;
                end
            end

            DONE: begin
                nextState = IDLE;
            end

            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Memory-side request registers. The granted requester's fields are
    // captured once, so the requester may change its inputs while it waits.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // High only in the first busy cycle.
            mem_req <= grantI || grantD;
            if (grantI) begin
                mem_addr  <= i_addr;
                mem_wr    <= 1'b0;
                mem_wdata <= '0;
            end else if (grantD) begin
                mem_addr  <= d_addr;
                mem_wr    <= d_wr;
                mem_wdata <= d_wdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Starvation streak: counts D grants that were made while I was waiting.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else if (grantI) begin
            streak <= '0;
        end else if (grantD) begin
            if (!i_req) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Timeout counter: 0 in the first busy cycle, +1 in each later one.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmoCnt <= '0;
        end else if (grantI || grantD) begin
            tmoCnt <= '0;
        end else if (busy && !busyDone && !timeoutHit) begin
            tmoCnt <= tmoCnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Completion strobes, read data and the error flag. The strobes are
    // registered on the busy->DONE transition, so they are high exactly
    // during the DONE cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            err     <= 1'b0;
        end else begin
            i_done <= busyDone && (state == IBUSY);
            d_done <= busyDone && (state == DBUSY);

            if (busyDone && (state == IBUSY)) begin
                i_rdata <= mem_rdata;
            end

            // A write leaves the previous read data in place.
            if (busyDone && (state == DBUSY) && !mem_wr) begin
                d_rdata <= mem_rdata;
            end

            if (timeoutHit) begin
                err <= 1'b1;
            end
        end
    end

endmodule
